// File: rtl/bus_arbiter4.sv
// Four-requester bus arbiter: registered one-hot grant with round-robin or
// fixed-priority selection, per-tenure hold limit and an AND-OR bus mux.
module bus_arbiter4 #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    parameter int RR       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   din,
    output logic [3:0]           gnt,
    output logic [1:0]           gnt_id,
    output logic                 busy,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  holder;
    logic [3:0]  cand;
    logic [1:0]  winner;

    // RR searches upward from last+1 with wrap; fixed priority from index 0.
    function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (RR != 0) idx = base + 2'(k + 1);
            else         idx = 2'(k);
            if (!found && m[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        holder = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (gnt_q[i]) holder = 2'(i);
        end
    end

    // From IDLE every requester is a candidate; in GRANT the holder is masked.
    assign cand   = (state_q == IDLE) ? req : (req & ~gnt_q);
    assign winner = pick(cand, last_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d    = GRANT;
                    gnt_d      = 4'b0001 << winner;
                    hold_cnt_d = '0;
                    last_d     = winner;
                end
            end
            GRANT: begin
                if (!req[holder] || hold_cnt_q == 4'(MAX_HOLD - 1)) begin
                    hold_cnt_d = '0;
                    if (cand != 4'b0000) begin
                        gnt_d  = 4'b0001 << winner;
                        last_d = winner;
                    end else if (!req[holder]) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end else begin
                        last_d = holder;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
            last_q     <= 2'd3;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        bus_out = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            bus_out = bus_out | (din[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}});
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = holder;
    assign busy      = (state_q == GRANT);
    assign bus_valid = |(gnt_q & req);

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: one round-robin and one fixed-priority instance,
// hand-derived expected grants queued per cycle and compared after each edge.
module tb_bus_arbiter4;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req_rr, req_fp;
    logic [4*W-1:0] din;
    logic [3:0]     gnt_rr, gnt_fp;
    logic [1:0]     gnt_id_rr, gnt_id_fp;
    logic           busy_rr, busy_fp;
    logic [W-1:0]   bus_out_rr, bus_out_fp;
    logic           bus_valid_rr, bus_valid_fp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] g_rr;
        logic [3:0] g_fp;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] prev_rr = 4'b0000;
    logic [3:0] prev_fp = 4'b0000;

    bus_arbiter4 #(.WIDTH(W), .MAX_HOLD(4), .RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req_rr), .din(din),
        .gnt(gnt_rr), .gnt_id(gnt_id_rr), .busy(busy_rr),
        .bus_out(bus_out_rr), .bus_valid(bus_valid_rr)
    );

    bus_arbiter4 #(.WIDTH(W), .MAX_HOLD(4), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req_fp), .din(din),
        .gnt(gnt_fp), .gnt_id(gnt_id_fp), .busy(busy_fp),
        .bus_out(bus_out_fp), .bus_valid(bus_valid_fp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_bus(input logic [3:0] g);
        case (g)
            4'b0001: exp_bus = din[7:0];
            4'b0010: exp_bus = din[15:8];
            4'b0100: exp_bus = din[23:16];
            4'b1000: exp_bus = din[31:24];
            default: exp_bus = '0;
        endcase
    endfunction

    function automatic logic [1:0] exp_id(input logic [3:0] g);
        case (g)
            4'b0010: exp_id = 2'd1;
            4'b0100: exp_id = 2'd2;
            4'b1000: exp_id = 2'd3;
            default: exp_id = 2'd0;
        endcase
    endfunction

    // One clock: drive at negedge, check combinational outputs against the
    // still-current grant, then check registered outputs after the edge.
    task automatic cyc(input logic rn, input logic [3:0] r_rr, input logic [3:0] r_fp,
                       input logic [3:0] e_rr, input logic [3:0] e_fp);
        exp_t e;
        @(negedge clk);
        rst_n  = rn;
        req_rr = r_rr;
        req_fp = r_fp;
        #1;
        check("rr_valid_pre", 32'(bus_valid_rr), 32'(|(prev_rr & r_rr)));
        check("rr_bus_pre", 32'(bus_out_rr), 32'(exp_bus(prev_rr)));
        check("fp_valid_pre", 32'(bus_valid_fp), 32'(|(prev_fp & r_fp)));
        check("fp_bus_pre", 32'(bus_out_fp), 32'(exp_bus(prev_fp)));
        e.g_rr = e_rr;
        e.g_fp = e_fp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("rr_gnt", 32'(gnt_rr), 32'(e.g_rr));
        check("rr_gnt_id", 32'(gnt_id_rr), 32'(exp_id(e.g_rr)));
        check("rr_busy", 32'(busy_rr), 32'(e.g_rr != 4'b0000));
        check("rr_bus", 32'(bus_out_rr), 32'(exp_bus(e.g_rr)));
        check("fp_gnt", 32'(gnt_fp), 32'(e.g_fp));
        check("fp_gnt_id", 32'(gnt_id_fp), 32'(exp_id(e.g_fp)));
        check("fp_busy", 32'(busy_fp), 32'(e.g_fp != 4'b0000));
        check("fp_bus", 32'(bus_out_fp), 32'(exp_bus(e.g_fp)));
        prev_rr = e.g_rr;
        prev_fp = e.g_fp;
    endtask

    task automatic rr_n(input int n, input logic [3:0] r, input logic [3:0] g);
        for (int i = 0; i < n; i++) cyc(1'b1, r, 4'b0000, g, 4'b0000);
    endtask

    task automatic fp_n(input int n, input logic [3:0] r, input logic [3:0] g);
        for (int i = 0; i < n; i++) cyc(1'b1, 4'b0000, r, 4'b0000, g);
    endtask

    initial begin
        rst_n  = 1'b0;
        req_rr = 4'b1111;
        req_fp = 4'b1111;
        din    = {8'h3C, 8'hA5, 8'h5A, 8'hC3};

        // Reset held with all requesting, then rotation with wrap-around.
        cyc(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        rr_n(4, 4'b1111, 4'b0001);
        rr_n(4, 4'b1111, 4'b0010);
        rr_n(4, 4'b1111, 4'b0100);
        rr_n(4, 4'b1111, 4'b1000);
        rr_n(1, 4'b1111, 4'b0001);
        rr_n(1, 4'b0000, 4'b0000);

        // Sole requester keeps the bus across expiries, then releases.
        rr_n(10, 4'b0100, 4'b0100);
        rr_n(1, 4'b0000, 4'b0000);

        // Early release hands off with no idle cycle; new holder gets 4 cycles.
        rr_n(2, 4'b0011, 4'b0001);
        rr_n(1, 4'b0010, 4'b0010);
        rr_n(3, 4'b0011, 4'b0010);
        rr_n(1, 4'b0011, 4'b0001);
        rr_n(1, 4'b0000, 4'b0000);

        // Reset in the second cycle of a tenure; pointer returns to 3.
        rr_n(2, 4'b0010, 4'b0010);
        cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        rr_n(1, 4'b1111, 4'b0001);
        rr_n(1, 4'b0000, 4'b0000);

        // Fixed priority: holder masking alternates 0 and 1.
        fp_n(4, 4'b0011, 4'b0001);
        fp_n(4, 4'b0011, 4'b0010);
        fp_n(4, 4'b0011, 4'b0001);
        fp_n(1, 4'b0000, 4'b0000);

        // Higher-priority request does not preempt the current holder.
        fp_n(1, 4'b0100, 4'b0100);
        fp_n(3, 4'b0101, 4'b0100);
        fp_n(1, 4'b0101, 4'b0001);
        fp_n(1, 4'b0000, 4'b0000);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Four-requester arbiter and sequencer for the shared data bus of the priority-encoder lab.
- Replaces multiple continuous drivers on one net with a single registered one-hot grant and an AND-OR bus mux; no tristate values.
- Grant policy: round-robin or fixed priority, with a per-tenure hold limit so no requester can starve the others.

Parameters:
WIDTH, 8, data width per requester and of the bus.
MAX_HOLD, 4, maximum consecutive grant cycles per tenure; legal range 1..15.
RR, 1, 1 = round-robin, 0 = fixed priority (index 0 highest).

Ports:
clk  input  1  system clock; everything updates on the rising edge.
rst_n  input  1  reset; synchronous, active-low.
req  input  4  request, one bit per requester; held high while the requester wants the bus.
din  input  4*WIDTH  packed requester data; requester i occupies din[i*WIDTH +: WIDTH].
gnt  output  4  registered one-hot grant; all zero when idle.
gnt_id  output  2  binary index of the current holder; 0 when idle.
busy  output  1  registered; high while any grant is active.
bus_out  output  WIDTH  combinational: OR over i of (din_i AND {WIDTH{gnt[i]}}); 0 when idle.
bus_valid  output  1  combinational: |(gnt & req).

Behaviour:
- Reset: rst_n low at a posedge clears the following on that edge:
  - gnt=0, gnt_id=0, busy=0, hold_cnt=0.
  - Round-robin pointer last=3, so requester 0 wins first.
  - As a result, bus_out=0 and bus_valid=0.
- Reset mid-tenure aborts the grant on that edge, with no completion cycle. Reset overrides all other events.
- States:
  - IDLE (busy=0).
  - GRANT (busy=1, holder h).
- IDLE -> GRANT: at the first posedge with req!=0. The winner's gnt bit is high after that edge (latency 1 cycle). hold_cnt=0 and last=winner.
- Winner selection:
  - RR=1: first set bit of the candidate mask, searching from (last+1) mod 4 upward with wrap-around.
  - RR=0: lowest set index.
- GRANT, each posedge, evaluated in priority order:
  - a) req[h]=0 (release; also wins over a simultaneous expiry):
    - If (req & ~gnt) is nonzero, grant the new winner on the same edge. No idle bubble; hold_cnt=0.
    - Otherwise go to IDLE with gnt=0.
  - b) hold_cnt==MAX_HOLD-1 (expiry):
    - Arbitrate over candidate mask req & ~gnt (holder masked out, both modes). If nonzero, grant the winner with hold_cnt=0.
    - If zero, re-grant h as a new tenure: gnt unchanged, hold_cnt=0.
  - c) Otherwise: keep gnt and increment hold_cnt.
- Tenure length: a continuously requesting holder keeps the grant exactly MAX_HOLD cycles. MAX_HOLD=1 forces rotation every cycle when others request.
- Requests arriving or dropping from non-holders never preempt the holder and have no effect until the next arbitration edge.
- last updates only on grant edges, including a self-re-grant at expiry.
- hold_cnt is 4 bits wide and never exceeds MAX_HOLD-1.
- gnt is always one-hot or zero. gnt_id and busy are derived from the registered gnt (registered encoding), never from req.
- bus_valid low with busy high means the holder released this cycle: the bus data is stale and consumers must ignore it.
- Inputs are X/Z-free by contract. The bench drives all req bits to 0 or 1, never Z.

Test Plan:
- Default parameters (WIDTH=8, MAX_HOLD=4, RR=1) unless a scenario states otherwise.
- Reset: hold rst_n=0 for 2 cycles with req=1111 -> gnt=0000, busy=0, bus_out=0x00. First edge after release -> gnt=0001, gnt_id=0.
- Sole requester: req=0100, din2=0xA5 for 10 cycles -> gnt=0100 continuously through expiries, bus_out=0xA5, bus_valid=1. Drop req -> bus_valid=0 in that cycle; next edge gnt=0000, busy=0, bus_out=0x00.
- Rotation: req=1111 constant -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again (wrap-around).
- Early release handoff: req=0011 from idle -> gnt=0001. req0 drops after 2 grant cycles -> next edge gnt=0010 with no idle cycle, and it is held 4 cycles.
- Fixed priority, RR=0, req=0011 constant -> 0001 x4, 0010 x4, 0001 x4 (masking prevents starvation). Raise req0 while requester 2 holds under req=0100 -> no preemption; gnt=0001 only after requester 2's expiry.
- Reset mid-tenure: rst_n=0 during the 2nd cycle of gnt=0010 -> next edge gnt=0000, busy=0. After release with req=1111 -> gnt=0001 (pointer reset to 3).
